// File: rtl/memory_stage.sv
// Y86-64 SEQ data-memory stage: 8-byte little-endian loads/stores with combinational reads.
// It also holds the sticky processor status register.
module memory_stage #(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  icode,
    input  logic        instr_valid,
    input  logic        imem_error,
    input  logic [63:0] valE,
    input  logic [63:0] valA,
    input  logic [63:0] valP,
    output logic [63:0] valM,
    output logic        dmem_error,
    output logic [1:0]  stat
);

    localparam int          NUM_LANES = 8;
    localparam int          AW        = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
    localparam logic [63:0] TOP_ADDR  = 64'(MEM_BYTES - NUM_LANES);

    typedef enum logic [1:0] {
        S_AOK = 2'b00,
        S_HLT = 2'b01,
        S_ADR = 2'b10,
        S_INS = 2'b11
    } stat_t;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [63:0] addr;
        logic [63:0] wdata;
    } mem_req_t;

    logic [7:0] mem [MEM_BYTES];

    mem_req_t                       req;
    logic                           legal;
    logic                           we;
    logic [NUM_LANES-1:0][7:0]      rbytes;
    stat_t                          stat_q;
    stat_t                          stat_d;

    always_comb begin
        req = '0;
        unique case (icode)
            4'h4: begin req.wr = 1'b1; req.addr = valE; req.wdata = valA; end
            4'h5: begin req.rd = 1'b1; req.addr = valE; end
            4'h8: begin req.wr = 1'b1; req.addr = valE; req.wdata = valP; end
            4'h9: begin req.rd = 1'b1; req.addr = valA; end
            4'hA: begin req.wr = 1'b1; req.addr = valE; req.wdata = valA; end
            4'hB: begin req.rd = 1'b1; req.addr = valA; end
            default: ;
        endcase
    end

    // Full 64-bit compare: high address bits never alias back into the array.
    assign legal      = (req.addr <= TOP_ADDR);
    assign dmem_error = (req.rd | req.wr) & ~legal;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        logic [AW-1:0] idx;
        assign idx       = req.addr[AW-1:0] + AW'(g);
        assign rbytes[g] = mem[idx];
    end

    assign valM = (req.rd && legal) ? rbytes : '0;

    always_comb begin
        stat_d = stat_q;
        if (stat_q == S_AOK) begin
            if (imem_error)        stat_d = S_ADR;
            else if (dmem_error)   stat_d = S_ADR;
            else if (!instr_valid) stat_d = S_INS;
            else if (icode == 4'h0) stat_d = S_HLT;
            else                   stat_d = S_AOK;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stat_q <= S_AOK;
        else        stat_q <= stat_d;
    end

    assign stat = stat_q;

    assign we = req.wr && legal && (stat_q == S_AOK) && !imem_error && instr_valid;

    // Array has no reset value; rst_n only blocks a store landing on an edge while reset is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n && we) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                mem[req.addr[AW-1:0] + AW'(i)] <= req.wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: a vector table plus hand-written sequences for
// sticky status, same-cycle read-before-write, and reset-suppressed stores.
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  icode;
    logic        instr_valid;
    logic        imem_error;
    logic [63:0] valE, valA, valP;
    logic [63:0] valM;
    logic        dmem_error;
    logic [1:0]  stat;

    int n_chk  = 0;
    int n_fail = 0;

    localparam logic [1:0] AOK = 2'b00, HLT = 2'b01, ADR = 2'b10, INS = 2'b11;

    memory_stage #(.MEM_BYTES(1024)) dut (
        .clk(clk), .rst_n(rst_n), .icode(icode), .instr_valid(instr_valid),
        .imem_error(imem_error), .valE(valE), .valA(valA), .valP(valP),
        .valM(valM), .dmem_error(dmem_error), .stat(stat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  icode;
        logic        iv;
        logic        ie;
        logic [63:0] e, a, p;
        logic [63:0] m;
        logic        d;
        logic [1:0]  st;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic [3:0] ic, logic iv, logic ie,
                                logic [63:0] e, logic [63:0] a, logic [63:0] p,
                                logic [63:0] m, logic d, logic [1:0] st);
        vec_t v;
        v.rst = rst; v.icode = ic; v.iv = iv; v.ie = ie;
        v.e = e; v.a = a; v.p = p; v.m = m; v.d = d; v.st = st;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] ic, input logic iv, input logic ie,
                         input logic [63:0] e, input logic [63:0] a, input logic [63:0] p);
        icode = ic; instr_valid = iv; imem_error = ie; valE = e; valA = a; valP = p;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(4'h1, 1'b1, 1'b0, 64'h0, 64'h0, 64'h0);
        #1 chk("reset_async_stat", 64'(stat), 64'(AOK));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        drive(4'h1, 1'b1, 1'b0, 64'h0, 64'h0, 64'h0);
        repeat (2) @(negedge clk);
        chk("reset_stat", 64'(stat), 64'(AOK));
        rst_n = 1'b1;

        //             rst   ic    iv    ie    valE                   valA                   valP     valM                   derr  stat
        vecs.push_back(mk(0, 4'h4, 1, 0, 64'h10,                64'h0123456789ABCDEF, 64'h0,   64'h0,                 0, AOK));
        vecs.push_back(mk(0, 4'h5, 1, 0, 64'h10,                64'h0,                64'h0,   64'h0123456789ABCDEF,  0, AOK));
        vecs.push_back(mk(0, 4'hA, 1, 0, 64'h3F8,               64'hAA,               64'h0,   64'h0,                 0, AOK));
        vecs.push_back(mk(0, 4'hB, 1, 0, 64'h10,                64'h3F8,              64'h0,   64'hAA,                0, AOK));
        vecs.push_back(mk(0, 4'h8, 1, 0, 64'h3F0,               64'h99,               64'h42,  64'h0,                 0, AOK));
        vecs.push_back(mk(0, 4'h9, 1, 0, 64'h3F8,               64'h3F0,              64'h0,   64'h42,                0, AOK));
        vecs.push_back(mk(0, 4'h4, 1, 0, 64'h11,                64'h1122334455667788, 64'h0,   64'h0,                 0, AOK));
        vecs.push_back(mk(0, 4'h5, 1, 0, 64'h10,                64'h0,                64'h0,   64'h22334455667788EF,  0, AOK));
        vecs.push_back(mk(0, 4'h3, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,              64'h0,   64'h0,                 0, AOK));
        vecs.push_back(mk(0, 4'h5, 1, 0, 64'h3F8,               64'h0,                64'h0,   64'hAA,                0, AOK));
        vecs.push_back(mk(0, 4'h5, 1, 0, 64'h3F9,               64'h0,                64'h0,   64'h0,                 1, ADR));
        vecs.push_back(mk(1, 4'h5, 1, 0, 64'h3F8,               64'h0,                64'h0,   64'hAA,                0, AOK));
        vecs.push_back(mk(0, 4'h5, 1, 0, 64'h1_0000_0010,       64'h0,                64'h0,   64'h0,                 1, ADR));
        vecs.push_back(mk(1, 4'hB, 1, 0, 64'h10,                64'h3FF,              64'h0,   64'h0,                 1, ADR));
        vecs.push_back(mk(1, 4'h9, 1, 0, 64'h0,                 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 64'h0,                1, ADR));
        vecs.push_back(mk(1, 4'h0, 1, 0, 64'h0,                 64'h0,                64'h0,   64'h0,                 0, HLT));
        vecs.push_back(mk(1, 4'h0, 1, 1, 64'h0,                 64'h0,                64'h0,   64'h0,                 0, ADR));
        vecs.push_back(mk(1, 4'h5, 0, 1, 64'h10,                64'h0,                64'h0,   64'h22334455667788EF,  0, ADR));
        vecs.push_back(mk(1, 4'h1, 0, 0, 64'h0,                 64'h0,                64'h0,   64'h0,                 0, INS));
        vecs.push_back(mk(1, 4'h4, 1, 0, 64'h3F9,               64'h5,                64'h0,   64'h0,                 1, ADR));

        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            @(negedge clk);
            drive(vecs[i].icode, vecs[i].iv, vecs[i].ie, vecs[i].e, vecs[i].a, vecs[i].p);
            #1;
            chk($sformatf("v%0d_valM", i), valM, vecs[i].m);
            chk($sformatf("v%0d_dmem_error", i), 64'(dmem_error), 64'(vecs[i].d));
            @(posedge clk);
            #1 chk($sformatf("v%0d_stat", i), 64'(stat), 64'(vecs[i].st));
        end

        // Sticky ADR blocks stores and ignores a later halt; reset clears it without a clock edge.
        do_reset();
        @(negedge clk); drive(4'h4, 1, 0, 64'h20, 64'h1234, 64'h0);
        @(negedge clk); drive(4'h5, 1, 0, 64'h3F9, 64'h0, 64'h0);
        #1 chk("sticky_dmem_error", 64'(dmem_error), 64'h1);
        @(posedge clk); #1 chk("sticky_to_adr", 64'(stat), 64'(ADR));
        @(negedge clk); drive(4'h4, 1, 0, 64'h20, 64'h5, 64'h0);
        @(posedge clk); #1 chk("sticky_hold_after_store", 64'(stat), 64'(ADR));
        @(negedge clk); drive(4'h0, 1, 0, 64'h0, 64'h0, 64'h0);
        @(posedge clk); #1 chk("sticky_hold_after_halt", 64'(stat), 64'(ADR));
        @(negedge clk); drive(4'h5, 1, 0, 64'h20, 64'h0, 64'h0);
        #1 chk("sticky_store_blocked", valM, 64'h1234);
        #2 rst_n = 1'b0;
        #1 chk("midcycle_async_reset", 64'(stat), 64'(AOK));
        @(negedge clk); rst_n = 1'b1;

        // Read in the store's own cycle sees old data; new data appears after the edge.
        @(negedge clk); drive(4'h4, 1, 0, 64'h30, 64'h3, 64'h0);
        @(negedge clk); drive(4'h5, 1, 0, 64'h30, 64'h0, 64'h0);
        #1 chk("rw_old_value", valM, 64'h3);
        drive(4'h4, 1, 0, 64'h30, 64'h7, 64'h0);
        #1 chk("rw_store_no_read", valM, 64'h0);
        icode = 4'h5;
        #1 chk("rw_same_cycle_pre_write", valM, 64'h3);
        icode = 4'h4;
        @(posedge clk); #1 icode = 4'h5;
        #1 chk("rw_after_edge", valM, 64'h7);

        // A store on an edge while reset is held must not land.
        @(negedge clk); drive(4'h4, 1, 0, 64'h40, 64'h9, 64'h0);
        @(negedge clk); drive(4'h4, 1, 0, 64'h40, 64'hBAD, 64'h0);
        rst_n = 1'b0;
        @(posedge clk); #1 chk("rst_store_stat", 64'(stat), 64'(AOK));
        @(negedge clk); rst_n = 1'b1; drive(4'h5, 1, 0, 64'h40, 64'h0, 64'h0);
        #1 chk("rst_store_suppressed", valM, 64'h9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
